// File: rtl/rps_stream_classifier_if.sv
// Row-in / result-out handshake bundle for rps_stream_classifier.
// Slave side is the classifier; master side is the binarizer plus the result consumer.
interface rps_stream_classifier_if #(
    parameter int unsigned LENGTH = 32,
    parameter int unsigned WIDTH  = 32
);
    localparam int unsigned SW = $clog2(LENGTH * WIDTH + 1);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned TW = $clog2(LENGTH);

    logic             row_valid;
    logic             row_ready;
    logic [WIDTH-1:0] row_data;
    logic             res_valid;
    logic             res_ready;
    logic [1:0]       res_class;
    logic [SW-1:0]    res_sum;
    logic [SW-1:0]    res_sum_left;
    logic [CW-1:0]    res_leftmost;
    logic [TW-1:0]    res_transitions;
    logic             res_empty;

    modport master (
        output row_valid, row_data, res_ready,
        input  row_ready, res_valid, res_class, res_sum, res_sum_left,
               res_leftmost, res_transitions, res_empty
    );

    modport slave (
        input  row_valid, row_data, res_ready,
        output row_ready, res_valid, res_class, res_sum, res_sum_left,
               res_leftmost, res_transitions, res_empty
    );
endinterface

// File: rtl/rps_stream_classifier.sv
// Streaming rock-paper-scissors classifier: buffers one binary frame, extracts
// pixel/left-region/leftmost features, counts probe-column transitions, then reports a class.
module rps_stream_classifier #(
    parameter int unsigned LENGTH       = 32,
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned LEFT         = 8,
    parameter int unsigned SHIFT        = 4,
    parameter int unsigned TRANS_TARGET = 4,
    parameter int unsigned LEFT_DIV     = 50
) (
    input  logic                         clk,
    input  logic                         rst,
    rps_stream_classifier_if.slave       bus
);
    localparam int unsigned SW     = $clog2(LENGTH * WIDTH + 1);
    localparam int unsigned CW     = $clog2(WIDTH);
    localparam int unsigned TW     = $clog2(LENGTH);
    localparam int unsigned PW     = CW + 1;
    localparam int unsigned THRESH = (LENGTH * WIDTH) / LEFT_DIV;

    typedef enum logic [1:0] {LOAD, SCAN, DONE} state_t;

    state_t           state;
    logic [TW-1:0]    idx;
    logic [SW-1:0]    sum;
    logic [SW-1:0]    sum_left;
    logic [CW-1:0]    leftmost;
    logic [TW-1:0]    trans;
    logic [WIDTH-1:0] buffer [LENGTH];

    logic             row_fire;
    logic [PW-1:0]    probe;
    logic             probe_ok;
    logic             step_hit;
    logic [TW-1:0]    trans_next;
    logic             empty_c;
    logic [1:0]       class_c;

    function automatic logic [SW-1:0] popcount(input logic [WIDTH-1:0] r, input int unsigned n);
        logic [SW-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (i < n) c = c + SW'(r[i]);
        end
        return c;
    endfunction

    function automatic logic [CW-1:0] lowest_bit(input logic [WIDTH-1:0] r);
        logic [CW-1:0] b;
        logic          found;
        b     = '1;
        found = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (r[i] && !found) begin
                b     = CW'(i);
                found = 1'b1;
            end
        end
        return b;
    endfunction

    assign bus.row_ready = (state == LOAD);
    assign bus.res_valid = (state == DONE);
    assign row_fire      = bus.row_valid && (state == LOAD);

    // Probe column is computed one bit wider so leftmost+SHIFT can never wrap back into range.
    always_comb begin
        probe      = PW'(leftmost) + PW'(SHIFT);
        empty_c    = (sum == '0);
        probe_ok   = !empty_c && (probe < PW'(WIDTH));
        step_hit   = probe_ok &&
                     (buffer[idx][probe[CW-1:0]] != buffer[idx + TW'(1)][probe[CW-1:0]]);
        trans_next = trans + TW'(step_hit);
        if (empty_c)                              class_c = 2'b11;
        else if (trans_next == TW'(TRANS_TARGET)) class_c = 2'b10;
        else if (sum_left > SW'(THRESH))          class_c = 2'b01;
        else                                      class_c = 2'b00;
    end

    // Frame storage is never reset; it is always fully rewritten before a scan reads it.
    always_ff @(posedge clk) begin
        if (!rst && row_fire) buffer[idx] <= bus.row_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= LOAD;
            idx                 <= '0;
            sum                 <= '0;
            sum_left            <= '0;
            leftmost            <= '1;
            trans               <= '0;
            bus.res_class       <= '0;
            bus.res_sum         <= '0;
            bus.res_sum_left    <= '0;
            bus.res_leftmost    <= '1;
            bus.res_transitions <= '0;
            bus.res_empty       <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (bus.row_valid) begin
                        sum      <= sum + popcount(bus.row_data, WIDTH);
                        sum_left <= sum_left + popcount(bus.row_data, LEFT);
                        if ((|bus.row_data) && (lowest_bit(bus.row_data) < leftmost))
                            leftmost <= lowest_bit(bus.row_data);
                        if (idx == TW'(LENGTH - 1)) begin
                            idx   <= '0;
                            state <= SCAN;
                        end else begin
                            idx <= idx + TW'(1);
                        end
                    end
                end
                SCAN: begin
                    trans <= trans_next;
                    if (idx == TW'(LENGTH - 2)) begin
                        idx                 <= '0;
                        state               <= DONE;
                        bus.res_class       <= class_c;
                        bus.res_sum         <= sum;
                        bus.res_sum_left    <= sum_left;
                        bus.res_leftmost    <= leftmost;
                        bus.res_transitions <= trans_next;
                        bus.res_empty       <= empty_c;
                    end else begin
                        idx <= idx + TW'(1);
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state    <= LOAD;
                        sum      <= '0;
                        sum_left <= '0;
                        leftmost <= '1;
                        trans    <= '0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_rps_stream_classifier.sv
// Self-checking bench for rps_stream_classifier: directed frame table, multi-cycle
// corner sequences (backpressure, mid-frame reset) and random frames against a feature model.
module tb_rps_stream_classifier;
    localparam int LENGTH       = 32;
    localparam int WIDTH        = 32;
    localparam int LEFT         = 8;
    localparam int SHIFT        = 4;
    localparam int TRANS_TARGET = 4;
    localparam int THRESH       = (LENGTH * WIDTH) / 50;
    localparam int ALL_ONES_COL = (1 << $clog2(WIDTH)) - 1;

    typedef logic [WIDTH-1:0] frame_t [LENGTH];

    typedef struct {
        int cls;
        int sum;
        int sum_left;
        int leftmost;
        int trans;
        int empty;
    } exp_t;

    typedef struct {
        string  name;
        frame_t frame;
        exp_t   exp;
    } vec_t;

    logic clk;
    logic rst;
    int   cycle   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    rps_stream_classifier_if #(.LENGTH(LENGTH), .WIDTH(WIDTH)) bus ();

    rps_stream_classifier #(
        .LENGTH(LENGTH), .WIDTH(WIDTH), .LEFT(LEFT), .SHIFT(SHIFT),
        .TRANS_TARGET(TRANS_TARGET), .LEFT_DIV(50)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feature extraction straight from the classification rules, column by column.
    function automatic exp_t model(input frame_t f);
        exp_t e;
        int   lm;
        int   p;
        e.sum = 0; e.sum_left = 0; e.trans = 0;
        lm = WIDTH;
        for (int r = 0; r < LENGTH; r++)
            for (int c = 0; c < WIDTH; c++)
                if (f[r][c]) begin
                    e.sum++;
                    if (c < LEFT) e.sum_left++;
                    if (c < lm) lm = c;
                end
        e.empty    = (e.sum == 0) ? 1 : 0;
        e.leftmost = e.empty ? ALL_ONES_COL : lm;
        p = lm + SHIFT;
        if (!e.empty && p < WIDTH)
            for (int r = 0; r < LENGTH - 1; r++)
                if (f[r][p] != f[r+1][p]) e.trans++;
        if (e.empty)                      e.cls = 3;
        else if (e.trans == TRANS_TARGET) e.cls = 2;
        else if (e.sum_left > THRESH)     e.cls = 1;
        else                              e.cls = 0;
        return e;
    endfunction

    task automatic send_row(input logic [WIDTH-1:0] row, input bit gaps, output int acc_cycle);
        bit acc;
        int waitc;
        if (gaps) begin
            bus.row_valid = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
        end
        bus.row_valid = 1'b1;
        bus.row_data  = row;
        acc = 1'b0;
        waitc = 0;
        acc_cycle = cycle;
        while (!acc && waitc < 1000) begin
            acc = bus.row_ready;
            acc_cycle = cycle;
            tick();
            waitc++;
        end
        if (!acc) check("row_accept_timeout", int'(acc), 1);
        bus.row_valid = 1'b0;
    endtask

    task automatic send_frame(input frame_t f, input bit gaps, output int acc_cycle);
        for (int r = 0; r < LENGTH; r++) send_row(f[r], gaps, acc_cycle);
    endtask

    task automatic wait_result(input string name, input exp_t e, input int acc_cycle);
        int waitc;
        waitc = 0;
        while (!bus.res_valid && waitc < 200) begin
            tick();
            waitc++;
        end
        check({name, "_res_valid"}, int'(bus.res_valid), 1);
        check({name, "_latency"}, cycle - acc_cycle, LENGTH);
        check({name, "_class"}, int'(bus.res_class), e.cls);
        check({name, "_sum"}, int'(bus.res_sum), e.sum);
        check({name, "_sum_left"}, int'(bus.res_sum_left), e.sum_left);
        check({name, "_leftmost"}, int'(bus.res_leftmost), e.leftmost);
        check({name, "_trans"}, int'(bus.res_transitions), e.trans);
        check({name, "_empty"}, int'(bus.res_empty), e.empty);
    endtask

    task automatic clear_frame(output frame_t f);
        for (int r = 0; r < LENGTH; r++) f[r] = '0;
    endtask

    vec_t   vecs [5];
    frame_t fr;
    exp_t   ex;
    int     acc_c;

    initial begin
        // Directed frames with hand-derived expectations.
        for (int i = 0; i < 5; i++) clear_frame(vecs[i].frame);
        vecs[0].name = "zero";
        vecs[0].exp  = '{cls: 3, sum: 0, sum_left: 0, leftmost: 31, trans: 0, empty: 1};
        vecs[1].name = "trans4";
        vecs[1].frame[0][5] = 1'b1;
        for (int r = 4; r < 8; r++) vecs[1].frame[r][9] = 1'b1;
        for (int r = 12; r < 16; r++) vecs[1].frame[r][9] = 1'b1;
        vecs[1].exp  = '{cls: 2, sum: 9, sum_left: 1, leftmost: 5, trans: 4, empty: 0};
        vecs[2].name = "left_heavy";
        for (int r = 0; r < 4; r++) vecs[2].frame[r] = 32'h0000_00FF;
        vecs[2].exp  = '{cls: 1, sum: 32, sum_left: 32, leftmost: 0, trans: 1, empty: 0};
        vecs[3].name = "left_at_thresh";
        for (int r = 0; r < 20; r++) vecs[3].frame[r] = 32'h0000_0001;
        vecs[3].exp  = '{cls: 0, sum: 20, sum_left: 20, leftmost: 0, trans: 0, empty: 0};
        vecs[4].name = "probe_oob";
        vecs[4].frame[0][30] = 1'b1;
        vecs[4].exp  = '{cls: 0, sum: 1, sum_left: 0, leftmost: 30, trans: 0, empty: 0};

        rst = 1'b1;
        bus.row_valid = 1'b0;
        bus.row_data  = '0;
        bus.res_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_row_ready", int'(bus.row_ready), 1);
        check("rst_res_valid", int'(bus.res_valid), 0);
        check("rst_class", int'(bus.res_class), 0);
        check("rst_sum", int'(bus.res_sum), 0);
        check("rst_leftmost", int'(bus.res_leftmost), ALL_ONES_COL);
        check("rst_trans", int'(bus.res_transitions), 0);

        bus.res_ready = 1'b1;
        for (int pass = 0; pass < 2; pass++)
            for (int i = 0; i < 5; i++) begin
                send_frame(vecs[i].frame, bit'(pass), acc_c);
                wait_result({vecs[i].name, pass ? "_gaps" : ""}, vecs[i].exp, acc_c);
            end

        // Result backpressure while rows are offered.
        tick();
        bus.res_ready = 1'b0;
        send_frame(vecs[1].frame, 1'b0, acc_c);
        bus.row_valid = 1'b1;
        bus.row_data  = '1;
        wait_result("bp", vecs[1].exp, acc_c);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp_res_valid", int'(bus.res_valid), 1);
            check("bp_row_ready", int'(bus.row_ready), 0);
            check("bp_class", int'(bus.res_class), 2);
            check("bp_sum", int'(bus.res_sum), 9);
            check("bp_trans", int'(bus.res_transitions), 4);
        end
        bus.res_ready = 1'b1;
        bus.row_valid = 1'b0;
        tick();
        check("bp_release_row_ready", int'(bus.row_ready), 1);
        check("bp_release_res_valid", int'(bus.res_valid), 0);
        send_frame(vecs[2].frame, 1'b0, acc_c);
        wait_result("after_bp", vecs[2].exp, acc_c);

        // Reset in the middle of a frame discards the partial rows.
        tick();
        for (int r = 0; r < 10; r++) send_row('1, 1'b0, acc_c);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_row_ready", int'(bus.row_ready), 1);
        check("midrst_res_valid", int'(bus.res_valid), 0);
        check("midrst_sum", int'(bus.res_sum), 0);
        check("midrst_leftmost", int'(bus.res_leftmost), ALL_ONES_COL);
        send_frame(vecs[0].frame, 1'b0, acc_c);
        wait_result("midrst_zero", vecs[0].exp, acc_c);

        // Random frames shaped to reach every class.
        for (int n = 0; n < 24; n++) begin
            int mode;
            int lm;
            bit on;
            mode = int'($urandom_range(0, 3));
            clear_frame(fr);
            case (mode)
                0: for (int r = 0; r < LENGTH; r++)
                       fr[r] = $urandom & $urandom & $urandom & $urandom;
                1: begin
                    lm = int'($urandom_range(0, WIDTH - 1));
                    fr[$urandom_range(0, LENGTH - 1)][lm] = 1'b1;
                    on = 1'b0;
                    for (int r = 0; r < LENGTH; r++) begin
                        if ($urandom_range(0, 5) == 0) on = ~on;
                        if (on && lm + SHIFT < WIDTH) fr[r][lm + SHIFT] = 1'b1;
                    end
                end
                2: if ($urandom_range(0, 1) == 1)
                       fr[$urandom_range(0, LENGTH - 1)][$urandom_range(0, WIDTH - 1)] = 1'b1;
                default: for (int r = 0; r < LENGTH; r++)
                       if ($urandom_range(0, 2) == 0) fr[r] = $urandom & 32'h0000_00FF;
            endcase
            ex = model(fr);
            send_frame(fr, bit'($urandom_range(0, 1)), acc_c);
            bus.res_ready = ($urandom_range(0, 3) != 0);
            wait_result("rand", ex, acc_c);
            if (!bus.res_ready) begin
                repeat ($urandom_range(1, 5)) tick();
                check("rand_hold_class", int'(bus.res_class), ex.cls);
                bus.res_ready = 1'b1;
            end
        end

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
